// File: rtl/dds_osc_voice.sv
// Single-voice DDS oscillator: phase accumulator, optional portamento, four waveforms.
// Optional glide slew is compiled in when DDS_GLIDE_EN is defined.
module dds_osc_voice #(
  parameter int          OUT_W     = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      ADDER,
  input  logic             GATE,
  input  logic [1:0]       WAVE,
  input  logic [3:0]       GLIDE,
  input  logic             SAMPLE_EN,
  output logic [OUT_W-1:0] OUT,
  output logic             OUT_VALID,
  output logic             SYNC
);

  localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic              gate_prev_reg;
  logic [31:0]       acc_reg;
  logic [31:0]       cur_adder_reg, cur_adder_next;
  logic [15:0]       lfsr_reg, lfsr_next;
  logic [1:0]        wave_reg;
  logic              run_reg;
  logic              wrap_reg;
  logic              pend_reg;
  logic [32:0]       sum;
  logic [OUT_W-1:0]  wave_val;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (GATE && !gate_prev_reg) state_next = RUN;
      RUN:     if (!GATE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sum       = {1'b0, acc_reg} + {1'b0, cur_adder_reg};
  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

`ifdef DDS_GLIDE_EN
  logic signed [32:0] diff, step;

  // Step is at least one LSB toward the target, and never larger than the gap.
  always_comb begin
    diff = $signed({1'b0, ADDER}) - $signed({1'b0, cur_adder_reg});
    step = diff >>> GLIDE;
    if (step == '0 && diff != '0) step = diff[32] ? -33'sd1 : 33'sd1;
    cur_adder_next = cur_adder_reg + step[31:0];
  end
`else
  logic glide_unused;
  assign glide_unused   = ^GLIDE;
  assign cur_adder_next = ADDER;
`endif

  // Waveform is shaped from the phase already advanced by the strobe one edge earlier.
  always_comb begin
    wave_val = acc_reg[31 -: OUT_W];
    case (wave_reg)
      2'd1:    wave_val = {OUT_W{acc_reg[31]}};
      2'd2:    wave_val = acc_reg[31] ? ~acc_reg[30 -: OUT_W] : acc_reg[30 -: OUT_W];
      2'd3:    wave_val = lfsr_reg[15 -: OUT_W];
      default: wave_val = acc_reg[31 -: OUT_W];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      gate_prev_reg <= 1'b0;
      acc_reg       <= '0;
      cur_adder_reg <= '0;
      lfsr_reg      <= LFSR_SEED;
      wave_reg      <= '0;
      run_reg       <= 1'b0;
      wrap_reg      <= 1'b0;
      pend_reg      <= 1'b0;
      OUT           <= MIDSCALE;
      OUT_VALID     <= 1'b0;
      SYNC          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gate_prev_reg <= GATE;
      pend_reg      <= SAMPLE_EN;
      // The state decision for this edge governs the accumulate, so gate edges win.
      if (state_next == IDLE) acc_reg <= '0;
      else if (SAMPLE_EN)     acc_reg <= sum[31:0];
      if (SAMPLE_EN) begin
        cur_adder_reg <= cur_adder_next;
        lfsr_reg      <= lfsr_next;
        wave_reg      <= WAVE;
        run_reg       <= (state_next == RUN);
        wrap_reg      <= (state_next == RUN) && sum[32];
      end
      OUT_VALID <= pend_reg;
      SYNC      <= pend_reg && run_reg && wrap_reg;
      if (pend_reg) OUT <= run_reg ? wave_val : MIDSCALE;
    end
  end

endmodule

// File: doc/dds_osc_voice.md
# dds_osc_voice

Single-voice DDS oscillator that consumes the 32-bit phase increment produced by the note-to-increment stage. It integrates the increment into a phase accumulator on each sample strobe, optionally slews the increment toward a new target (portamento), and emits one 12-bit unsigned waveform sample per strobe to the mixer/DAC stage. It gates output with a note-on level and flags each phase wrap for hard-sync use.

## Interface
Parameters:
- OUT_W, 12, output sample width; taken from accumulator MSBs.
- LFSR_SEED, 16'hACE1, noise generator reset value; must be nonzero.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ADDER  in  32  target phase increment from the upstream stage; may change any cycle.
- GATE  in  1  note active level.
- WAVE  in  2  waveform select: 0 saw, 1 square, 2 triangle, 3 noise.
- GLIDE  in  4  glide shift; 0 = no glide.
- SAMPLE_EN  in  1  sample-rate strobe; may be high on consecutive cycles.
- OUT  out  OUT_W  unsigned sample; midscale = 12'h800.
- OUT_VALID  out  1  one-cycle pulse marking a new OUT.
- SYNC  out  1  one-cycle pulse, coincident with OUT_VALID, when that sample's accumulate wrapped.

## Operation
- State machine with two states, IDLE and RUN:
  - IDLE → RUN on a sampled GATE rising edge. `acc` is already 0.
  - RUN → IDLE on GATE low. `acc` is cleared to 0 on the same edge.
- Phase accumulator `acc[31:0]`:
  - Updates only in RUN on cycles with SAMPLE_EN: acc <= acc + cur_adder, modulo 2^32.
  - The carry-out is captured as `wrap`.
  - In IDLE, acc holds 0.
- Current increment `cur_adder[31:0]`, updated on SAMPLE_EN in both states, after the acc add has used the old value:
  - GLIDE==0: cur_adder <= ADDER.
  - Otherwise: diff = ADDER − cur_adder (33-bit signed); step = diff >>> GLIDE (arithmetic shift).
  - If step==0 and diff≠0, step = ±1 by the sign of diff.
  - cur_adder <= cur_adder + step. It never overshoots ADDER.
- Waveform, computed from the updated acc (the `p` below):
  - Saw = p[31:20].
  - Square = p[31] ? 12'hFFF : 12'h000.
  - Triangle = p[31] ? ~p[30:19] : p[30:19].
  - Noise = lfsr[15:4].
- Noise LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift left with feedback into bit 0. It advances on every SAMPLE_EN regardless of state or WAVE.
- In IDLE, OUT = 12'h800 for every sample. OUT_VALID still pulses and SYNC stays 0.
- WAVE and GLIDE are sampled on the SAMPLE_EN cycle. Changes take effect at the next sample without a phase reset.

## Timing
- Reset values: OUT=12'h800, OUT_VALID=0, SYNC=0, acc=0, cur_adder=0, lfsr=LFSR_SEED, state IDLE.
- Latency: SAMPLE_EN high at edge k → acc/cur_adder/lfsr update at edge k → OUT, OUT_VALID, SYNC register at edge k+1. OUT_VALID is high for exactly one cycle after edge k+1.
- Back-to-back SAMPLE_EN is supported. This gives one OUT_VALID per strobe, pipelined.
- GATE edge and SAMPLE_EN on the same cycle:
  - State changes first.
  - Rising edge: the sample is computed from acc=0+cur_adder.
  - Falling edge: the sample is 12'h800 and acc is cleared.
- Exact 2^32 wrap (acc+cur_adder = 2^32) → acc=0, SYNC=1.
- RST mid-operation overrides everything on that edge, including a pending OUT_VALID, which is dropped.

## Configuration
- DDS_GLIDE_EN:
  - Defined: glide slew as specified.
  - Undefined: cur_adder <= ADDER on every SAMPLE_EN, and GLIDE is ignored. The slew datapath is not synthesised.

## Test plan
- Reset, GATE=1, WAVE=0, ADDER=32'h1000_0000, GLIDE=0, SAMPLE_EN every 4 cycles → first OUT=0 (cur_adder still 0 on first strobe), then 12'h100, 12'h200…; SYNC on the sample where acc returns to 0; OUT_VALID 2 edges after each strobe.
- WAVE=1 and WAVE=2 at ADDER=32'h0800_0000 → square toggles 000/FFF every 16 samples; triangle peaks at 12'hFFF and returns toward 0, period 32 samples.
- GATE low mid-note → next sample OUT=12'h800 and SYNC=0; GATE high again → samples restart from phase 0.
- DDS_GLIDE_EN defined, GLIDE=2, ADDER step 0→32'h0000_0100 → cur_adder 0x40, 0x70, 0x94… monotonically reaching exactly 0x100 with no overshoot; GLIDE=0 → immediate jump.
- WAVE=3 after reset, 3 strobes → OUT follows LFSR states from 16'hACE1 per the tap polynomial; RST asserted on a strobe cycle → no OUT_VALID, outputs at reset values.
